// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: CPU register map, uart-side indices, status bit positions and poll engine states.
package uart_fifo_pkg;
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_POP = 3'd1;
  localparam logic [2:0] REG_STAT = 3'd2;
  localparam logic [2:0] REG_CLR = 3'd3;
  localparam logic [2:0] REG_CNT = 3'd4;
  localparam logic [2:0] REG_TXIE = 3'd5;
  localparam logic [2:0] UA_DATA = 3'd0;
  localparam logic [2:0] UA_RXNEW = 3'd1;
  localparam logic [2:0] UA_TXIDLE = 3'd2;
  localparam int ST_RX_NE = 24;
  localparam int ST_TX_FULL = 25;
  localparam int ST_TX_EMPTY = 26;
  localparam int ST_RX_OVF = 27;
  localparam int ST_TX_OVF = 28;
  typedef enum logic [2:0] {POLL_RX, RD_RX, CLR_RX, POLL_TX, WR_TX} eng_state_t;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: 8-bit synchronous FIFO; a same-cycle pop frees room for a push while full.
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [7:0]            i_din,
  output logic [7:0]            o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [7:0] r_mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wp, r_rp;
  logic [DEPTH_LOG2:0] r_cnt;
  logic w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == FULL;
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_dout = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
    end
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: CPU-side TX/RX byte FIFOs plus a poll engine that masters the uart register port.
// UART_FIFO_TXIRQ_EN adds register 5, a tx-empty interrupt enable qualified by the last polled uart idle.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic [2:0]  u_a,
  output logic [31:0] u_d,
  output logic        u_we,
  input  logic [31:0] u_spo
);
  eng_state_t r_state;
  logic r_rx_ovf, r_tx_ovf, r_irq, r_u_we;
  logic [2:0] r_u_a;
  logic [31:0] r_u_d, w_stat;
  logic [7:0] w_tx_head, w_rx_head;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [DEPTH_LOG2:0] w_tx_cnt, w_rx_cnt;
  logic w_tx_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_clr, w_txie, w_txirq, w_unused;
  assign w_tx_wr = we && a == REG_DATA;
  assign w_tx_push = w_tx_wr && !w_tx_full;
  assign w_tx_pop = r_state == WR_TX;
  assign w_rx_push = r_state == RD_RX;
  assign w_rx_pop = we && a == REG_POP;
  assign w_clr = we && a == REG_CLR;
  assign w_unused = ^{d[23:0], u_spo[23:0], w_tx_cnt};
  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(clk), .rst_n(rst), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_din(d[31:24]),
    .o_dout(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_cnt)
  );
  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(clk), .rst_n(rst), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_din(u_spo[31:24]),
    .o_dout(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_cnt)
  );
`ifdef UART_FIFO_TXIRQ_EN
  logic r_txie, r_tx_idle;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_txie <= 1'b0;
      r_tx_idle <= 1'b0;
    end else begin
      if (we && a == REG_TXIE) r_txie <= d[24];
      if (r_state == POLL_TX) r_tx_idle <= u_spo[24];
    end
  assign w_txie = r_txie;
  assign w_txirq = r_txie && w_tx_empty && r_tx_idle;
`else
  assign w_txie = 1'b0;
  assign w_txirq = 1'b0;
`endif
  always_comb begin
    w_stat = '0;
    w_stat[ST_RX_NE] = !w_rx_empty;
    w_stat[ST_TX_FULL] = w_tx_full;
    w_stat[ST_TX_EMPTY] = w_tx_empty;
    w_stat[ST_RX_OVF] = r_rx_ovf;
    w_stat[ST_TX_OVF] = r_tx_ovf;
  end
  assign spo = a == REG_DATA ? {w_rx_empty ? 8'h00 : w_rx_head, 24'h0}
             : a == REG_STAT ? w_stat
             : a == REG_CNT  ? {8'(w_rx_cnt), 24'h0}
             : a == REG_TXIE ? {7'd0, w_txie, 24'h0}
             : 32'h0;
  // A set in the same cycle as a clear wins, so no overflow event is lost.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_rx_ovf <= (r_rx_ovf && !w_clr) || (w_rx_push && w_rx_full && !w_rx_pop);
      r_tx_ovf <= (r_tx_ovf && !w_clr) || (w_tx_wr && w_tx_full);
      r_irq <= !w_rx_empty || w_txirq;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= POLL_RX;
      r_u_a <= UA_RXNEW;
      r_u_we <= 1'b0;
      r_u_d <= '0;
    end else begin
      r_u_we <= 1'b0;
      r_u_d <= '0;
      case (r_state)
        POLL_RX:
          if (u_spo[24]) begin
            r_state <= RD_RX;
            r_u_a <= UA_DATA;
          end else begin
            r_state <= POLL_TX;
            r_u_a <= UA_TXIDLE;
          end
        RD_RX: begin
          r_state <= CLR_RX;
          r_u_a <= UA_RXNEW;
          r_u_we <= 1'b1;
        end
        CLR_RX: begin
          r_state <= POLL_TX;
          r_u_a <= UA_TXIDLE;
        end
        POLL_TX:
          if (u_spo[24] && !w_tx_empty) begin
            r_state <= WR_TX;
            r_u_a <= UA_DATA;
            r_u_we <= 1'b1;
            r_u_d <= {w_tx_head, 24'h0};
          end else begin
            r_state <= POLL_RX;
            r_u_a <= UA_RXNEW;
          end
        default: begin
          r_state <= POLL_RX;
          r_u_a <= UA_RXNEW;
        end
      endcase
    end
  assign irq = r_irq;
  assign u_a = r_u_a;
  assign u_d = r_u_d;
  assign u_we = r_u_we;
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed steps with random bytes, checked against queue-based FIFO/flag models and a behavioural uart.
module tb_uart_fifo;
  logic clk = 0, rst = 0, we = 0, irq, u_we;
  logic [2:0] a = 0, u_a;
  logic [31:0] d = 0, spo, u_d, u_spo;
  int vectors = 0, miscompares = 0;
  uart_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
    .u_a(u_a), .u_d(u_d), .u_we(u_we), .u_spo(u_spo)
  );
  always #5 clk = ~clk;
  // behavioural uart: busy for 4 cycles after a data write, rx_new set by injection, cleared by a write to index 1
  logic [7:0] m_rx_byte = 0, inj_byte = 0;
  logic m_rx_new = 0, m_hold = 0;
  int m_busy = 0, inj_cnt = 0, inj_seen = 0, clr_n = 0, sent_n = 0;
  logic [31:0] sent [256];
  always_comb
    u_spo = u_a == 3'd0 ? {m_rx_byte, 24'h0}
          : u_a == 3'd1 ? {7'd0, m_rx_new, 24'h0}
          : u_a == 3'd2 ? {7'd0, m_busy == 0 && !m_hold, 24'h0}
          : 32'h0;
  always @(posedge clk) begin
    if (u_we && u_a == 3'd0) begin
      sent[8'(sent_n)] <= u_d;
      sent_n <= sent_n + 1;
      m_busy <= 4;
    end else if (m_busy > 0) m_busy <= m_busy - 1;
    if (inj_seen != inj_cnt) begin
      m_rx_new <= 1'b1;
      m_rx_byte <= inj_byte;
      inj_seen <= inj_cnt;
    end else if (u_we && u_a == 3'd1) begin
      m_rx_new <= 1'b0;
      clr_n <= clr_n + 1;
    end
  end
  // reference model: FIFO contents as queues, sticky flags as bits
  logic [7:0] tx_q[$], rx_q[$];
  bit m_txovf = 0, m_rxovf = 0;
  function automatic logic [31:0] stat_exp();
    return {3'b000, m_txovf, m_rxovf, tx_q.size() == 0, tx_q.size() == 16, rx_q.size() != 0, 24'h0};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] ra, input logic [31:0] rdat);
    a = ra;
    d = rdat;
    we = 1;
    tick();
    we = 0;
    d = 0;
  endtask
  task automatic rd(input logic [2:0] ra, output logic [31:0] v);
    a = ra;
    #1;
    v = spo;
  endtask
  task automatic chk_rd(input string tag, input logic [2:0] ra, input logic [31:0] exp);
    logic [31:0] v;
    rd(ra, v);
    check(tag, v, exp);
  endtask
  task automatic wait_sent(input int n, input int bound, input string tag);
    int k = 0;
    while (sent_n < n && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(sent_n >= n), 32'h1);
  endtask
  task automatic wait_clr(input int n, input int bound, input string tag);
    int k = 0;
    while (clr_n < n && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(clr_n >= n), 32'h1);
  endtask
  task automatic wait_rx(input int bound, input string tag);
    logic [31:0] v;
    int k = 0;
    rd(3'd2, v);
    while (!v[24] && k < bound) begin
      tick();
      rd(3'd2, v);
      k++;
    end
    check(tag, 32'(v[24]), 32'h1);
  endtask
  task automatic check_sent(input int base, input int n);
    for (int k = 0; k < n; k++)
      check($sformatf("sent%0d", k), sent[8'(base + k)], {tx_q.pop_front(), 24'h0});
  endtask
  task automatic inject(input logic [7:0] b);
    int k = 0;
    while (m_rx_new && k < 20) begin
      tick();
      k++;
    end
    check("inject_ready", 32'(m_rx_new), 32'h0);
    inj_byte = b;
    inj_cnt++;
    tick();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] v;
    logic [7:0] b;
    logic ok;
    int base;
    tick(3);
    check("rst_u_a", 32'(u_a), 32'h1);
    check("rst_u_we", 32'(u_we), 32'h0);
    check("rst_u_d", u_d, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1;
    tick(2);
    chk_rd("rst_stat", 3'd2, stat_exp());
    chk_rd("rst_cnt", 3'd4, 32'h0);
    chk_rd("rst_data", 3'd0, 32'h0);
    // TX with the uart idle
    base = sent_n;
    wr(3'd0, 32'h4100_0000);
    tx_q.push_back(8'h41);
    wait_sent(base + 1, 5, "tx_latency");
    wr(3'd0, 32'h4200_0000);
    tx_q.push_back(8'h42);
    wait_sent(base + 2, 20, "tx_second");
    check_sent(base, 2);
    chk_rd("tx_done_stat", 3'd2, stat_exp());
    base = sent_n;
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      wr(3'd0, {b, 24'h0});
      tx_q.push_back(b);
    end
    wait_sent(base + 3, 60, "tx_burst");
    check_sent(base, 3);
    check("tx_irq_quiet", 32'(irq), 32'h0);
    // RX of one byte
    base = clr_n;
    inject(8'h5A);
    rx_q.push_back(8'h5A);
    ok = 0;
    for (int k = 0; k <= 3 && !ok; k++) begin
      if (k > 0) tick();
      rd(3'd2, v);
      ok = v[24];
    end
    check("rx_latency", 32'(ok), 32'h1);
    tick();
    check("rx_irq", 32'(irq), 32'h1);
    check("rx_clr_once", 32'(clr_n - base), 32'h1);
    chk_rd("rx_stat", 3'd2, stat_exp());
    chk_rd("rx_data", 3'd0, 32'h5A00_0000);
    chk_rd("rx_cnt", 3'd4, 32'h0100_0000);
    wr(3'd1, 32'h0);
    void'(rx_q.pop_front());
    chk_rd("rx_pop_stat", 3'd2, stat_exp());
    tick();
    check("rx_irq_clear", 32'(irq), 32'h0);
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      inject(b);
      rx_q.push_back(b);
      wait_rx(8, "rx_rand_arrive");
      chk_rd("rx_rand_data", 3'd0, {rx_q[0], 24'h0});
      wr(3'd1, 32'h0);
      void'(rx_q.pop_front());
    end
    chk_rd("rx_rand_stat", 3'd2, stat_exp());
    // TX overflow with the uart held busy
    m_hold = 1;
    tick(4);
    base = sent_n;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      wr(3'd0, {b, 24'h0});
      tx_q.push_back(b);
    end
    chk_rd("tx_full", 3'd2, stat_exp());
    wr(3'd0, 32'hEE00_0000);
    m_txovf = 1;
    chk_rd("tx_ovf", 3'd2, stat_exp());
    wr(3'd3, 32'h0);
    m_txovf = 0;
    chk_rd("tx_ovf_clr", 3'd2, stat_exp());
    m_hold = 0;
    wait_sent(base + 16, 250, "tx_drain");
    check_sent(base, 16);
    tick(12);
    check("tx_no_extra", 32'(sent_n - base), 32'd16);
    chk_rd("tx_drain_stat", 3'd2, stat_exp());
    // RX overflow, then a CPU pop coinciding with an engine push at full
    base = clr_n;
    for (int n = 0; n < 17; n++) begin
      b = 8'($urandom);
      inject(b);
      if (rx_q.size() < 16) rx_q.push_back(b);
      else m_rxovf = 1;
    end
    wait_clr(base + 17, 10, "rx_ovf_wait");
    chk_rd("rx_cnt_full", 3'd4, {8'(rx_q.size()), 24'h0});
    chk_rd("rx_ovf", 3'd2, stat_exp());
    check("rx_ovf_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h0);
    m_rxovf = 0;
    b = 8'($urandom);
    inject(b);
    ok = 0;
    for (int k = 0; k < 8 && !ok; k++) begin
      if (k > 0) tick();
      ok = u_a == 3'd0 && !u_we;
    end
    check("rd_rx_seen", 32'(ok), 32'h1);
    wr(3'd1, 32'h0);
    void'(rx_q.pop_front());
    rx_q.push_back(b);
    tick(2);
    chk_rd("rx_coinc_cnt", 3'd4, {8'(rx_q.size()), 24'h0});
    chk_rd("rx_coinc_stat", 3'd2, stat_exp());
    for (int n = 0; n < 16; n++) begin
      chk_rd("rx_drain", 3'd0, {rx_q[0], 24'h0});
      wr(3'd1, 32'h0);
      void'(rx_q.pop_front());
    end
    wr(3'd1, 32'h0);
    chk_rd("rx_empty_pop_cnt", 3'd4, 32'h0);
    chk_rd("rx_empty_data", 3'd0, 32'h0);
    // asynchronous reset during WR_TX
    b = 8'($urandom);
    inject(b);
    wait_rx(8, "arst_rx_arrive");
    wr(3'd0, 32'hC300_0000);
    ok = 0;
    for (int k = 0; k < 6 && !ok; k++) begin
      if (k > 0) tick();
      ok = u_we && u_a == 3'd0;
    end
    check("wr_tx_seen", 32'(ok), 32'h1);
    #2 rst = 0;
    #1;
    check("arst_u_we", 32'(u_we), 32'h0);
    check("arst_u_a", 32'(u_a), 32'h1);
    check("arst_u_d", u_d, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    tx_q.delete();
    rx_q.delete();
    m_txovf = 0;
    m_rxovf = 0;
    chk_rd("arst_stat", 3'd2, stat_exp());
    #1 rst = 1;
    check("resume_u_a", 32'(u_a), 32'h1);
    base = sent_n;
    tick(2);
    check("resume_no_send", 32'(sent_n - base), 32'h0);
    chk_rd("resume_stat", 3'd2, stat_exp());
    chk_rd("resume_cnt", 3'd4, 32'h0);
    b = 8'($urandom);
    wr(3'd0, {b, 24'h0});
    tx_q.push_back(b);
    wait_sent(base + 1, 6, "resume_tx");
    check_sent(base, 1);
`ifdef UART_FIFO_TXIRQ_EN
    wr(3'd5, 32'h0100_0000);
    tick(12);
    chk_rd("txie_rd", 3'd5, 32'h0100_0000);
    check("txirq_idle", 32'(irq), 32'h1);
    base = sent_n;
    wr(3'd0, 32'h7700_0000);
    tx_q.push_back(8'h77);
    tick();
    check("txirq_drop", 32'(irq), 32'h0);
    wait_sent(base + 1, 6, "txirq_tx");
    check_sent(base, 1);
    tick(15);
    check("txirq_back", 32'(irq), 32'h1);
`else
    wr(3'd5, 32'h0100_0000);
    tick(12);
    chk_rd("txie_absent", 3'd5, 32'h0);
    check("txirq_absent", 32'(irq), 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Bus-side buffering stage sitting between the CPU bus and the uart core. It replaces direct CPU access to uart.
- CPU side: byte-wide TX and RX FIFOs, a status register and a level interrupt.
- UART side: a small poll engine masters the uart register interface (addresses 0x00/0x01/0x02).
- The engine never issues a read and a write in the same transaction, so software no longer babysits the uart idle/rx_new flags.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).

Ports:
clk  in  1  system clock, shared with uart.
rst  in  1  asynchronous active-low reset. Top level drives uart's rst from the inverse of this signal.
a  in  3  CPU register index (word index; software uses x4 byte offsets).
d  in  32  CPU write data; byte lane is d[31:24].
we  in  1  CPU write strobe, one cycle per write.
spo  out  32  CPU read data, combinational on a; byte returned in [31:24], others zero.
irq  out  1  registered level interrupt.
u_a  out  3  uart register index.
u_d  out  32  uart write data, {byte, 24'b0}.
u_we  out  1  uart write strobe.
u_spo  in  32  uart read data, combinational on u_a.

Behaviour:
- Reset values: irq=0, u_a=3'b001, u_we=0, u_d=0. Both FIFOs empty, sticky flags 0, engine in POLL_RX.
- CPU register map:
  - a=0 write: push d[31:24] to TX FIFO. If TX is full, the byte is dropped and tx_ovf is set.
  - a=0 read: RX head byte, or 0 if RX is empty.
  - a=1 write: pop RX. Ignored when empty.
  - a=2 read: [24] rx_nonempty, [25] tx_full, [26] tx_empty, [27] rx_ovf, [28] tx_ovf.
  - a=3 write: clears both sticky flags.
  - a=4 read: RX count in [31:24], zero-extended.
  - Other addresses read 0; writes to them are ignored.
- Engine FSM; one state per cycle, u_a/u_we/u_d decoded from state:
  - POLL_RX (u_a=1): if u_spo[24], go to RD_RX; else go to POLL_TX.
  - RD_RX (u_a=0): push u_spo[31:24] to RX FIFO. If RX is full, discard and set rx_ovf. Go to CLR_RX.
  - CLR_RX (u_a=1, u_we=1): clears uart rx_new. Go to POLL_TX.
  - POLL_TX (u_a=2): if u_spo[24] and TX is non-empty, go to WR_TX; else go to POLL_RX.
  - WR_TX (u_a=0, u_we=1, u_d={TX head,24'b0}): pop TX. Go to POLL_RX.
- Latency:
  - CPU TX write to u_we is at most 5 cycles when the uart is idle.
  - uart rx_new to RX push is at most 3 cycles.
- Uart busy flag: the uart reports busy from the cycle after WR_TX, so the engine never double-writes.
- Simultaneous events:
  - CPU pop and engine push to RX in the same cycle: both take effect. A full RX with a same-cycle pop accepts the push.
  - CPU push to a full TX in the same cycle as an engine pop: the push is dropped. Full is sampled before the cycle.
- Pointers wrap modulo 2^DEPTH_LOG2. Counts are DEPTH_LOG2+1 bits wide and saturate at exactly DEPTH.
- irq is registered: irq<=rx_nonempty, one cycle after the RX state changes.
- Reset mid-operation: FIFO contents are lost and the engine restarts at POLL_RX. A uart transmit already in flight completes by itself.

Optional Feature:
Macro: UART_FIFO_TXIRQ_EN.
- When defined: adds register a=5 (write d[24] = tx_empty interrupt enable, read it back in [24]); reset value 0. irq<=rx_nonempty | (txirq_en & tx_empty & uart idle as last polled).
- When undefined: a=5 reads 0 and ignores writes; irq is RX-only.

Decomposition:
- Shared package: register index constants (REG_DATA=0, REG_POP=1, REG_STAT=2, REG_CLR=3, REG_CNT=4, REG_TXIE=5), uart-side indices (UA_DATA=0, UA_RXNEW=1, UA_TXIDLE=2), status bit positions, and the engine state encoding (3-bit, 5 states).
- One sub-module, fifo_sync: a parameterised 8-bit synchronous FIFO with push/pop/full/empty/count. It is instantiated twice.

Test Plan:
- Reset then CPU writes 0x41, 0x42 at a=0, with the uart model idle → u_we pulses with u_d=0x41000000, then 0x42000000 once the model reports idle again; tx_empty=1 afterwards.
- Uart model raises rx_new with byte 0x5A → within 3 cycles a=2 reads [24]=1, a=0 reads 0x5A000000, a=4 reads 0x01000000; one CLR_RX write is observed; irq=1 the next cycle.
- Push 17 bytes to TX with the uart held busy → tx_full=1 after 16 pushes, the 17th sets tx_ovf; a=3 write clears it.
- Inject 17 RX bytes with no CPU pop → 17th discarded, rx_ovf=1, count reads 16. Then a CPU pop coincident with an engine push at full → count stays 16, byte accepted.
- Deassert rst asynchronously mid-WR_TX → all outputs at reset values immediately; after release, the engine resumes in POLL_RX with FIFOs empty.
- With UART_FIFO_TXIRQ_EN, write a=5 d=0x01000000 with TX empty and the uart idle → irq=1; push one byte → irq drops while the uart is busy.
